// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: round-robin mover of words from three input RAMs to three output buffers.
// Optional saturating drop counter enabled by defining RR_DROP_COUNT_EN.
module rr_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] wr_add1,
  input  logic [ADDR_W-1:0] wr_add2,
  input  logic [ADDR_W-1:0] wr_add3,
  output logic [ADDR_W-1:0] rd_add1,
  output logic [ADDR_W-1:0] rd_add2,
  output logic [ADDR_W-1:0] rd_add3,
  output logic              rden1,
  output logic              rden2,
  output logic              rden3,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wr1,
  output logic              out_wr2,
  output logic              out_wr3,
  input  logic              out_full1,
  input  logic              out_full2,
  input  logic              out_full3,
  output logic              busy,
  output logic [15:0]       drop_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, DELIVER, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr [3];
  logic [ADDR_W-1:0] rd_q [3];
  logic [ADDR_W-1:0] rd_d [3];
  logic [1:0] last_q, last_d, sel_q, sel_d, pick, dest;
  logic [1:0] c [3];
  logic [2:0] ne;
  logic [DATA_W-1:0] hold_q, hold_d, out_q, out_d, qs, word;
  logic full, strobe, done, start;
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  assign wr[0] = wr_add1;
  assign wr[1] = wr_add2;
  assign wr[2] = wr_add3;
  // Ports are indexed 0..2 internally; last_q==2 means port 3 was served last.
  always_comb begin
    for (int i = 0; i < 3; i++) ne[i] = rd_q[i] != wr[i];
    c[0] = inc3(last_q);
    c[1] = inc3(c[0]);
    c[2] = inc3(c[1]);
    pick = ne[c[0]] ? c[0] : ne[c[1]] ? c[1] : c[2];
    start = state_q == IDLE && en && |ne;
    qs = sel_q == 2'd0 ? q1 : sel_q == 2'd1 ? q2 : q3;
    word = state_q == DELIVER ? qs : hold_q;
    dest = word[1:0];
    full = dest == 2'd1 ? out_full1 : dest == 2'd2 ? out_full2 : out_full3;
    strobe = (state_q == DELIVER || state_q == HOLD) && dest != 2'd0 && !full;
    done = strobe || (state_q == DELIVER && dest == 2'd0);
    state_d = start ? ISSUE : state_q == ISSUE ? DELIVER :
              (state_q == DELIVER || state_q == HOLD) ? (done ? IDLE : HOLD) : IDLE;
    sel_d = start ? pick : sel_q;
    last_d = done ? sel_q : last_q;
    hold_d = state_q == DELIVER ? qs : hold_q;
    out_d = strobe ? word : out_q;
    for (int i = 0; i < 3; i++) rd_d[i] = rd_q[i] + ADDR_W'(done && sel_q == 2'(i));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      sel_q   <= 2'd0;
      hold_q  <= '0;
      out_q   <= '0;
      rd_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
    end
  end
  assign rd_add1  = rd_q[0];
  assign rd_add2  = rd_q[1];
  assign rd_add3  = rd_q[2];
  assign rden1    = state_q == ISSUE && sel_q == 2'd0;
  assign rden2    = state_q == ISSUE && sel_q == 2'd1;
  assign rden3    = state_q == ISSUE && sel_q == 2'd2;
  assign out_wr1  = strobe && dest == 2'd1;
  assign out_wr2  = strobe && dest == 2'd2;
  assign out_wr3  = strobe && dest == 2'd3;
  assign out_data = out_d;
  assign busy     = state_q != IDLE;
`ifdef RR_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
  always_comb drop_d = (state_q == DELIVER && dest == 2'd0 && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter: scoreboard bench; directed vectors push expected strobes, a monitor pops them.
module tb_rr_port_arbiter;
  logic clk = 0, reset = 0, en = 0;
  logic [11:0] wr_add1 = 0, wr_add2 = 0, wr_add3 = 0;
  logic [11:0] rd_add1, rd_add2, rd_add3;
  logic rden1, rden2, rden3, out_wr1, out_wr2, out_wr3, busy;
  logic out_full1 = 0, out_full2 = 0, out_full3 = 0;
  logic [31:0] q1 = 0, q2 = 0, q3 = 0, out_data;
  logic [15:0] drop_count;
  logic [31:0] mem1 [4096];
  logic [31:0] mem2 [4096];
  logic [31:0] mem3 [4096];
  typedef struct {logic [1:0] dest; logic [31:0] data;} exp_t;
  exp_t sbq [$];
  exp_t em;
  int pass_n = 0, total_n = 0;

  rr_port_arbiter dut (
    .clk(clk), .reset(reset), .en(en),
    .wr_add1(wr_add1), .wr_add2(wr_add2), .wr_add3(wr_add3),
    .rd_add1(rd_add1), .rd_add2(rd_add2), .rd_add3(rd_add3),
    .rden1(rden1), .rden2(rden2), .rden3(rden3),
    .q1(q1), .q2(q2), .q3(q3),
    .out_data(out_data), .out_wr1(out_wr1), .out_wr2(out_wr2), .out_wr3(out_wr3),
    .out_full1(out_full1), .out_full2(out_full2), .out_full3(out_full3),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rden1) q1 <= mem1[rd_add1];
    if (rden2) q2 <= mem2[rd_add2];
    if (rden3) q3 <= mem3[rd_add3];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  always @(negedge clk) begin
    if (out_wr1 | out_wr2 | out_wr3) begin
      chk("wr_onehot", $countones({out_wr3, out_wr2, out_wr1}), 1);
      if (sbq.size() == 0) chk("unexpected_strobe", {29'b0, out_wr3, out_wr2, out_wr1}, 0);
      else begin
        em = sbq.pop_front();
        chk("strobe_dest", {29'b0, out_wr3, out_wr2, out_wr1},
            em.dest == 2'd1 ? 32'd1 : em.dest == 2'd2 ? 32'd2 : 32'd4);
        chk("strobe_data", out_data, em.data);
      end
    end
    if (rden1 | rden2 | rden3) chk("rden_onehot", $countones({rden3, rden2, rden1}), 1);
  end

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 0; en = 0; wr_add1 = 0; wr_add2 = 0; wr_add3 = 0;
    out_full1 = 0; out_full2 = 0; out_full3 = 0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1;
  endtask

  initial begin
    int cyc, last, found;
    @(negedge clk);
    chk("rst_rd_add", {rd_add1, rd_add2, rd_add3[7:0]}, 0);
    chk("rst_ctl", {26'b0, rden1, rden2, rden3, out_wr1, out_wr2, out_wr3}, 0);
    chk("rst_data_busy", {out_data[30:0], busy}, 0);
    chk("rst_drop", {16'b0, drop_count}, 0);
    // basic latency: one word to buffer 2
    mem1[0] = 32'hA5A5_0002;
    sbq.push_back('{2'd2, 32'hA5A5_0002});
    @(posedge clk); #1;
    reset = 1; en = 1; wr_add1 = 1;
    @(negedge clk);
    chk("c0_rden", {29'b0, rden1, rden2, rden3}, 0);
    @(negedge clk);
    chk("c1_rden1", {31'b0, rden1}, 1);
    chk("c1_rd_add1", {20'b0, rd_add1}, 0);
    @(negedge clk);
    chk("c2_out_wr2", {31'b0, out_wr2}, 1);
    @(negedge clk);
    chk("c3_rd_add1", {20'b0, rd_add1}, 1);
    chk("c3_busy", {31'b0, busy}, 0);
    chk("hold_out_data", out_data, 32'hA5A5_0002);
    // round-robin over three ports, two words each
    do_reset();
    for (int i = 0; i < 2; i++) begin
      mem1[i] = 32'h1100_0001 + (i << 8);
      mem2[i] = 32'h2200_0001 + (i << 8);
      mem3[i] = 32'h3300_0001 + (i << 8);
    end
    for (int i = 0; i < 2; i++) begin
      sbq.push_back('{2'd1, 32'h1100_0001 + (i << 8)});
      sbq.push_back('{2'd1, 32'h2200_0001 + (i << 8)});
      sbq.push_back('{2'd1, 32'h3300_0001 + (i << 8)});
    end
    en = 1; wr_add1 = 2; wr_add2 = 2; wr_add3 = 2;
    cyc = 0; last = 0;
    for (int k = 0; k < 6; k++) begin
      found = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        cyc++;
        if (out_wr1) begin found = 1; break; end
      end
      chk("rr_strobe_seen", found, 1);
      chk("rr_strobe_cycle", cyc - last, k == 0 ? 3 : 3);
      last = cyc;
    end
    @(negedge clk);
    chk("rr_rd_adds", {rd_add1, rd_add2, rd_add3}, {12'd2, 12'd2, 12'd2});
    // backpressure on buffer 3 for ten HOLD cycles
    do_reset();
    mem3[0] = 32'hCAFE_0003;
    sbq.push_back('{2'd3, 32'hCAFE_0003});
    en = 1; wr_add3 = 1; out_full3 = 1;
    found = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (out_wr3) found++;
    end
    chk("hold_no_strobe", found, 0);
    chk("hold_rd_add3", {20'b0, rd_add3}, 0);
    chk("hold_busy", {31'b0, busy}, 1);
    @(posedge clk); #1;
    out_full3 = 0;
    @(negedge clk);
    chk("hold_release_wr3", {31'b0, out_wr3}, 1);
    @(negedge clk);
    chk("hold_rd_add3_after", {20'b0, rd_add3}, 1);
    // dropped word
    do_reset();
    mem1[0] = 32'h1234_5670;
    en = 1; wr_add1 = 1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("drop_rd_add1", {20'b0, rd_add1}, 1);
`ifdef RR_DROP_COUNT_EN
    chk("drop_count", {16'b0, drop_count}, 1);
`else
    chk("drop_count", {16'b0, drop_count}, 0);
`endif
    // pointer wrap: drain 4095 dropped words, then one real word at 4095
    do_reset();
    for (int i = 0; i < 4095; i++) mem1[i] = 32'h0;
    en = 1; wr_add1 = 12'd4095;
    for (int i = 0; i < 13000; i++) begin
      @(negedge clk);
      if (rd_add1 == 12'd4095) break;
    end
    chk("wrap_reach_4095", {20'b0, rd_add1}, 32'd4095);
`ifdef RR_DROP_COUNT_EN
    chk("wrap_drop_count", {16'b0, drop_count}, 32'd4095);
`else
    chk("wrap_drop_count", {16'b0, drop_count}, 0);
`endif
    mem1[4095] = 32'h7777_0002;
    sbq.push_back('{2'd2, 32'h7777_0002});
    @(posedge clk); #1;
    wr_add1 = 12'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_add1 == 12'd0) break;
    end
    chk("wrap_rd_add1", {20'b0, rd_add1}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_empty_idle", {31'b0, busy}, 0);
    // reset during HOLD
    do_reset();
    mem3[0] = 32'hBEEF_0003;
    en = 1; wr_add3 = 1; out_full3 = 1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 1);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_rd_add", {rd_add1, rd_add2, rd_add3[7:0]}, 0);
    chk("mid_rst_ctl", {26'b0, rden1, rden2, rden3, out_wr1, out_wr2, out_wr3}, 0);
    chk("mid_rst_data_busy", {out_data[30:0], busy}, 0);
    out_full3 = 0; wr_add3 = 0;
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 0);
    chk("post_rst_rd_add3", {20'b0, rd_add3}, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/rr_port_arbiter.md
RR_PORT_ARBITER -- requirements
Module: rr_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: input RAM address width; all pointers are ADDR_W bits.
REQ-002 Parameter DATA_W, default 32: packet word width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  level; arbitration permitted while high.
REQ-006 wr_add1, wr_add2, wr_add3  input  ADDR_W each  next-write address of input RAMs 1..3.
REQ-007 rd_add1, rd_add2, rd_add3  output  ADDR_W each  read address to input RAMs 1..3.
REQ-008 rden1, rden2, rden3  output  1 each  read enable to input RAMs 1..3.
REQ-009 q1, q2, q3  input  DATA_W each  input RAM read data, valid one cycle after rden.
REQ-010 out_data  output  DATA_W  word forwarded to output buffer.
REQ-011 out_wr1, out_wr2, out_wr3  output  1 each  single-cycle write strobe into output buffer 1..3.
REQ-012 out_full1, out_full2, out_full3  input  1 each  output buffer 1..3 cannot accept a word.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 drop_count  output  16  count of dropped words (see Configuration).

Function
REQ-015 Port n SHALL be non-empty iff rd_addn != wr_addn; compare and increment are modulo 2^ADDR_W (wrap 4095->0 with no special case).
REQ-016 FSM states SHALL be IDLE, ISSUE, DELIVER, HOLD.
REQ-017 IDLE: if en=1 and any port non-empty, select port by round-robin and go to ISSUE; else remain.
REQ-018 Round-robin SHALL search starting at the port after last_served (order 1->2->3->1); last_served resets to 3 so port 1 has first priority.
REQ-019 ISSUE: assert rden of selected port for exactly one cycle, rd_addn unchanged; go to DELIVER.
REQ-020 DELIVER: register qn into hold register; destination = word bits [1:0] (1..3 = output buffer 1..3, 0 = drop).
REQ-021 DELIVER, destination valid and its out_full=0: drive out_data = word, pulse matching out_wr for one cycle, increment rd_addn, update last_served, go to IDLE.
REQ-022 DELIVER, destination full: go to HOLD; word retained, no strobe.
REQ-023 HOLD: each cycle out_full of destination is sampled; when 0, pulse out_wr with held word, increment rd_addn, update last_served, go to IDLE.
REQ-024 DELIVER, destination 0: no strobe, increment rd_addn, update last_served, go to IDLE (word dropped).
REQ-025 Latency: en high and port non-empty in IDLE at cycle 0 -> rden at cycle 1 -> out_wr at cycle 2 (no backpressure); sustained throughput one word per 3 cycles.
REQ-026 At most one rden and at most one out_wr SHALL be high in any cycle.
REQ-027 en falling in ISSUE/DELIVER/HOLD SHALL NOT abort the word in flight; FSM completes it and then stays in IDLE.
REQ-028 wr_add changing in the same cycle as arbitration SHALL only be seen at the next IDLE evaluation.
REQ-029 out_data SHALL hold the last forwarded word between strobes.

Reset
REQ-030 reset low SHALL immediately force: state IDLE, rd_add1..3=0, rden*=0, out_wr*=0, out_data=0, busy=0, last_served=3, drop_count=0.
REQ-031 A word in flight at reset SHALL be lost; no strobe on reset release.
REQ-032 First arbitration after reset release SHALL occur no earlier than the first rising edge with reset high.

Configuration
REQ-033 Macro RR_DROP_COUNT_EN: defined -> drop_count increments on each REQ-024 drop, saturating at 16'hFFFF.
REQ-034 RR_DROP_COUNT_EN undefined -> drop_count tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-035 Reset, wr_add1=1, q1=32'hA5A5_0002, out_full*=0, en=1 -> rden1 cycle 1, out_wr2 with out_data=32'hA5A5_0002 cycle 2, rd_add1=1.
REQ-036 All three ports hold 2 words each, destinations 1 -> service order 1,2,3,1,2,3; six out_wr1 strobes, 3 cycles apart.
REQ-037 Word dest 3 with out_full3=1 for 10 cycles -> HOLD for 10 cycles, no strobe, out_wr3 in cycle after out_full3 falls, rd_add unchanged until then.
REQ-038 rd_add1=wr_add1-1=4095, one word -> forwarded, rd_add1 wraps to 0, port 1 empty.
REQ-039 Word with bits[1:0]=0 -> no out_wr, pointer advances, drop_count=1 with RR_DROP_COUNT_EN, 0 without.
REQ-040 reset asserted during HOLD -> all outputs at reset values that cycle, no strobe after release, rd_add*=0.
